// File: rtl/rom_arb.sv
// rom_arb: two-port round-robin arbiter in front of a single shared
// combinational ROM. Each transaction takes three cycles: a grant in
// IDLE, a one-cycle ROM read in ACCESS, and a one-cycle ack in RESP.
module rom_arb #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] adrs0,
  output logic          ack0,
  output logic [DW-1:0] dout0,
  input  logic          req1,
  input  logic [AW-1:0] adrs1,
  output logic          ack1,
  output logic [DW-1:0] dout1,
  output logic [AW-1:0] rom_adrs,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   grant;     // port owning the transaction in flight
  logic   last;      // port granted most recently
  logic   win1;      // port 1 wins the current arbitration

  // Arbitration: a lone requester wins; under contention the port not
  // granted last wins.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    win1 = 1'b0;
    if (req1 && (!req0 || !last)) win1 = 1'b1;
  end

  // Transaction FSM with registered outputs; reset aborts any transaction
  // in flight without an ack.
  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      last     <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      dout0    <= '0;
      dout1    <= '0;
      rom_adrs <= '0;
      rom_rd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          rom_rd <= 1'b0;
          if (req0 || req1) begin
            grant    <= win1;
            last     <= win1;
            rom_adrs <= win1 ? adrs1 : adrs0;
            rom_rd   <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rom_rd <= 1'b0;
          if (grant) begin
            dout1 <= rom_dout;
            ack1  <= 1'b1;
          end else begin
            dout0 <= rom_dout;
            ack0  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          rom_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arb.sv
// Directed self-checking bench for rom_arb with an XOR-pattern ROM model.
module tb_rom_arb;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] adrs0, adrs1;
  logic       ack0, ack1;
  logic [7:0] dout0, dout1;
  logic [7:0] rom_adrs;
  logic       rom_rd;
  logic [7:0] rom_dout;

  int checks = 0;
  int errors = 0;

  rom_arb #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .adrs0    (adrs0),
    .ack0     (ack0),
    .dout0    (dout0),
    .req1     (req1),
    .adrs1    (adrs1),
    .ack1     (ack1),
    .dout1    (dout1),
    .rom_adrs (rom_adrs),
    .rom_rd   (rom_rd),
    .rom_dout (rom_dout)
  );

  // ROM model: data is address XOR A5 while read is enabled, unknown otherwise.
  assign rom_dout = rom_rd ? (rom_adrs ^ 8'hA5) : 8'hxx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; adrs0 = '0; adrs1 = '0;
    #3;
    check("rst_ack0", 16'(ack0), 16'h0);
    check("rst_ack1", 16'(ack1), 16'h0);
    check("rst_rd", 16'(rom_rd), 16'h0);
    check("rst_adrs", 16'(rom_adrs), 16'h00);
    check("rst_dout0", 16'(dout0), 16'h00);
    check("rst_dout1", 16'(dout1), 16'h00);
    tick();
    rst = 1'b0;

    // Single-port read from port 0.
    req0 = 1'b1; adrs0 = 8'h03;
    tick();
    check("s_rd", 16'(rom_rd), 16'h1);
    check("s_adrs", 16'(rom_adrs), 16'h03);
    check("s_ack0_early", 16'(ack0), 16'h0);
    req0 = 1'b0;
    tick();
    check("s_rd_off", 16'(rom_rd), 16'h0);
    check("s_ack0", 16'(ack0), 16'h1);
    check("s_dout0", 16'(dout0), 16'hA6);
    check("s_ack1", 16'(ack1), 16'h0);
    tick();
    check("s_ack0_end", 16'(ack0), 16'h0);
    check("s_dout0_hold", 16'(dout0), 16'hA6);

    // Contention straight after reset: port 0 wins first.
    rst = 1'b1; #2; rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; adrs0 = 8'h00; adrs1 = 8'hFF;
    tick();
    check("c_adrs0", 16'(rom_adrs), 16'h00);
    check("c_rd0", 16'(rom_rd), 16'h1);
    tick();
    check("c_ack0", 16'(ack0), 16'h1);
    check("c_ack1_no", 16'(ack1), 16'h0);
    check("c_dout0", 16'(dout0), 16'hA5);
    req0 = 1'b0;
    tick();
    check("c_idle_ack0", 16'(ack0), 16'h0);
    tick();
    check("c_adrs1", 16'(rom_adrs), 16'hFF);
    check("c_rd1", 16'(rom_rd), 16'h1);
    tick();
    check("c_ack1", 16'(ack1), 16'h1);
    check("c_ack0_no", 16'(ack0), 16'h0);
    check("c_dout1", 16'(dout1), 16'h5A);
    check("c_dout0_hold", 16'(dout0), 16'hA5);
    req1 = 1'b0;
    tick();

    // Both requests held for 12 cycles: acks alternate 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1; adrs0 = 8'h11; adrs1 = 8'h22;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("h_ack0_%0d", i), 16'(ack0), (i % 6 == 2) ? 16'h1 : 16'h0);
      check($sformatf("h_ack1_%0d", i), 16'(ack1), (i % 6 == 5) ? 16'h1 : 16'h0);
      if (i % 6 == 2) check($sformatf("h_dout0_%0d", i), 16'(dout0), 16'hB4);
      if (i % 6 == 5) check($sformatf("h_dout1_%0d", i), 16'(dout1), 16'h87);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Address change after the grant edge is ignored.
    req1 = 1'b1; adrs1 = 8'h10;
    tick();
    check("a_adrs", 16'(rom_adrs), 16'h10);
    check("a_rd", 16'(rom_rd), 16'h1);
    adrs1 = 8'h20;
    tick();
    check("a_ack1", 16'(ack1), 16'h1);
    check("a_dout1", 16'(dout1), 16'hB5);
    req1 = 1'b0;
    tick();

    // Reset during ACCESS aborts; held request completes after release.
    req0 = 1'b1; adrs0 = 8'h44;
    tick();
    check("r_rd_pre", 16'(rom_rd), 16'h1);
    rst = 1'b1;
    #1;
    check("r_rd", 16'(rom_rd), 16'h0);
    check("r_ack0", 16'(ack0), 16'h0);
    check("r_ack1", 16'(ack1), 16'h0);
    check("r_dout0", 16'(dout0), 16'h00);
    check("r_dout1", 16'(dout1), 16'h00);
    check("r_adrs", 16'(rom_adrs), 16'h00);
    rst = 1'b0;
    tick();
    check("r_regrant_rd", 16'(rom_rd), 16'h1);
    check("r_regrant_adrs", 16'(rom_adrs), 16'h44);
    check("r_no_ack0", 16'(ack0), 16'h0);
    tick();
    check("r_ack0_done", 16'(ack0), 16'h1);
    check("r_dout0_done", 16'(dout0), 16'hE1);
    req0 = 1'b0;
    tick();

    // One-cycle req1 pulse while port 0 is in ACCESS is never served.
    req0 = 1'b1; adrs0 = 8'h5A;
    tick();
    req1 = 1'b1; adrs1 = 8'h77;
    tick();
    req1 = 1'b0;
    check("e_ack0", 16'(ack0), 16'h1);
    check("e_dout0", 16'(dout0), 16'hFF);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("e_ack1_%0d", i), 16'(ack1), 16'h0);
      check($sformatf("e_rd_%0d", i), 16'(rom_rd), 16'h0);
    end
    check("e_dout1", 16'(dout1), 16'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
